// File: rtl/fifo_ptr_ctrl_if.sv
// fifo_ptr_ctrl_if: control/status bundle between fifo_ns and fifo_ptr_ctrl.
//   next_state  state code proposed by fifo_ns
//   state       registered state fed back to fifo_ns
//   data_count  entries held, 0..DEPTH
//   we/wr_addr  register-file write strobe and address
//   re/rd_addr  register-file read strobe and address
//   full/empty  occupancy flags
//   wr_ack/wr_err/rd_ack/rd_err  result of the previous edge's operation
// Modports: master = fifo_ns side (drives next_state), slave = fifo_ptr_ctrl.
interface fifo_ptr_ctrl_if #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH),
    parameter int unsigned CW    = $clog2(DEPTH) + 1
);
    logic [2:0]    next_state;
    logic [2:0]    state;
    logic [CW-1:0] data_count;
    logic          we;
    logic [AW-1:0] wr_addr;
    logic          re;
    logic [AW-1:0] rd_addr;
    logic          full;
    logic          empty;
    logic          wr_ack;
    logic          wr_err;
    logic          rd_ack;
    logic          rd_err;

    modport master (
        output next_state,
        input  state, data_count, we, wr_addr, re, rd_addr,
        input  full, empty, wr_ack, wr_err, rd_ack, rd_err
    );

    modport slave (
        input  next_state,
        output state, data_count, we, wr_addr, re, rd_addr,
        output full, empty, wr_ack, wr_err, rd_ack, rd_err
    );
endinterface

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: state register and pointer/count control for the FIFO.
// Registers next_state from fifo_ns, keeps head/tail/data_count, drives the
// register-file strobes and addresses, and produces full/empty/ack/err flags.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    fifo_ptr_ctrl_if.slave (next_state in; everything else out)
// Build option: define FIFO_ERR_STICKY_EN to hold wr_err/rd_err high until
// the next matching ack edge (or reset) instead of pulsing for one cycle.
module fifo_ptr_ctrl #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH),
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic           clk,
    input  logic           reset,
    fifo_ptr_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        StInit   = 3'b000,
        StWrite  = 3'b001,
        StRead   = 3'b010,
        StWrErr  = 3'b101,
        StRdErr  = 3'b110,
        StNoOp   = 3'b111
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;
    logic          wr_ack_q, wr_err_q, rd_ack_q, rd_err_q;

    logic is_full, is_empty;
    logic do_write, do_read;
    logic wr_refuse, rd_refuse;

    assign is_full  = (count_q == CW'(DEPTH));
    assign is_empty = (count_q == '0);

    always_comb begin
        do_write  = 1'b0;
        do_read   = 1'b0;
        wr_refuse = 1'b0;
        rd_refuse = 1'b0;
        state_d   = StNoOp;
        unique case (bus.next_state)
            3'b000: state_d = StInit;
            3'b001: begin
                state_d   = StWrite;
                do_write  = !is_full;
                wr_refuse = is_full;
            end
            3'b010: begin
                state_d   = StRead;
                do_read   = !is_empty;
                rd_refuse = is_empty;
            end
            3'b101: begin
                state_d   = StWrErr;
                wr_refuse = 1'b1;
            end
            3'b110: begin
                state_d   = StRdErr;
                rd_refuse = 1'b1;
            end
            // 3'b111 and the illegal codes 3'b011/3'b100 all land on NO_OP.
            default: state_d = StNoOp;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StInit;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            wr_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
            rd_ack_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            // Pointers wrap naturally because DEPTH is a power of two.
            if (do_write) begin
                tail_q  <= tail_q + AW'(1);
                count_q <= count_q + CW'(1);
            end else if (do_read) begin
                head_q  <= head_q + AW'(1);
                count_q <= count_q - CW'(1);
            end
            wr_ack_q <= do_write;
            rd_ack_q <= do_read;
`ifdef FIFO_ERR_STICKY_EN
            wr_err_q <= wr_refuse | (wr_err_q & ~do_write);
            rd_err_q <= rd_refuse | (rd_err_q & ~do_read);
`else
            wr_err_q <= wr_refuse;
            rd_err_q <= rd_refuse;
`endif
        end
    end

    assign bus.state      = state_q;
    assign bus.data_count = count_q;
    assign bus.we         = do_write;
    assign bus.wr_addr    = tail_q;
    assign bus.re         = do_read;
    assign bus.rd_addr    = head_q;
    assign bus.full       = is_full;
    assign bus.empty      = is_empty;
    assign bus.wr_ack     = wr_ack_q;
    assign bus.wr_err     = wr_err_q;
    assign bus.rd_ack     = rd_ack_q;
    assign bus.rd_err     = rd_err_q;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// tb_fifo_ptr_ctrl: directed scenarios followed by random next_state/reset
// traffic, checked every cycle against a model that tracks total writes and
// reads since the last reset.
module tb_fifo_ptr_ctrl;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int CW    = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fifo_ptr_ctrl_if #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) bus ();

    fifo_ptr_ctrl #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: occupancy and addresses follow from writes/reads since reset.
    bit model_valid = 0;
    int n_wr = 0;
    int n_rd = 0;
    int m_state = 0;
    bit m_wr_ack = 0, m_wr_err = 0, m_rd_ack = 0, m_rd_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit rst_v, input logic [2:0] ns);
        int  cnt;
        bit  exp_we, exp_re, wr_bad, rd_bad;
        @(negedge clk);
        reset = rst_v;
        bus.next_state = ns;
        #1;
        cnt    = n_wr - n_rd;
        exp_we = (ns == 3'd1) && (cnt < DEPTH);
        exp_re = (ns == 3'd2) && (cnt > 0);
        if (model_valid) begin
            check("state",      32'(bus.state),      32'(m_state));
            check("data_count", 32'(bus.data_count), 32'(cnt));
            check("full",       32'(bus.full),       32'(cnt == DEPTH));
            check("empty",      32'(bus.empty),      32'(cnt == 0));
            check("we",         32'(bus.we),         32'(exp_we));
            check("re",         32'(bus.re),         32'(exp_re));
            check("wr_addr",    32'(bus.wr_addr),    32'(n_wr % DEPTH));
            check("rd_addr",    32'(bus.rd_addr),    32'(n_rd % DEPTH));
            check("wr_ack",     32'(bus.wr_ack),     32'(m_wr_ack));
            check("wr_err",     32'(bus.wr_err),     32'(m_wr_err));
            check("rd_ack",     32'(bus.rd_ack),     32'(m_rd_ack));
            check("rd_err",     32'(bus.rd_err),     32'(m_rd_err));
        end
        // Model update for the coming edge.
        if (rst_v) begin
            model_valid = 1;
            n_wr = 0;
            n_rd = 0;
            m_state = 0;
            m_wr_ack = 0; m_wr_err = 0; m_rd_ack = 0; m_rd_err = 0;
        end else if (model_valid) begin
            wr_bad = (ns == 3'd5) || (ns == 3'd1 && cnt == DEPTH);
            rd_bad = (ns == 3'd6) || (ns == 3'd2 && cnt == 0);
            m_state = (ns == 3'd3 || ns == 3'd4) ? 7 : int'(ns);
            if (exp_we) n_wr++;
            if (exp_re) n_rd++;
            m_wr_ack = exp_we;
            m_rd_ack = exp_re;
`ifdef FIFO_ERR_STICKY_EN
            m_wr_err = wr_bad || (m_wr_err && !exp_we);
            m_rd_err = rd_bad || (m_rd_err && !exp_re);
`else
            m_wr_err = wr_bad;
            m_rd_err = rd_bad;
`endif
        end
        @(posedge clk);
    endtask

    task automatic repeat_op(input int n, input logic [2:0] ns);
        for (int i = 0; i < n; i++) step(1'b0, ns);
    endtask

    initial begin
        bus.next_state = 3'd7;
        // Reset held for two cycles.
        step(1'b1, 3'd1);
        step(1'b1, 3'd1);
        // Fill, overflow, linger in NO_OP.
        repeat_op(8, 3'd1);
        repeat_op(1, 3'd1);
        repeat_op(3, 3'd7);
        // Drain, underflow.
        repeat_op(8, 3'd2);
        repeat_op(1, 3'd2);
        repeat_op(2, 3'd7);
        // Wrap: write 5, read 5, write 6, then illegal code 100 and 011.
        repeat_op(5, 3'd1);
        repeat_op(5, 3'd2);
        repeat_op(6, 3'd1);
        step(1'b0, 3'd4);
        step(1'b0, 3'd3);
        step(1'b0, 3'd5);
        step(1'b0, 3'd6);
        step(1'b0, 3'd0);
        // Reset mid-operation with four entries held.
        step(1'b1, 3'd7);
        repeat_op(4, 3'd1);
        step(1'b1, 3'd1);
        step(1'b0, 3'd7);
        // Random traffic biased toward writes/reads, occasional reset.
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] ns;
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 3)      ns = 3'd1;
            else if (sel < 6) ns = 3'd2;
            else              ns = 3'($urandom_range(0, 7));
            step(($urandom_range(0, 99) == 0), ns);
        end
        step(1'b0, 3'd7);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
